// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RV32I definitions for the instruction encoder: opcode values, the
// canonical NOP word, the encoding-format enum and a signed range helper.
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // addi x0,x0,0 -- substituted for any word that cannot be encoded
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SHIFT,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  // True when the two's-complement value v lies in [lo, hi]
  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// ---------------------------------------------------------------------------
// rv_imm_pack
// Combinational immediate packer. Classifies the opcode into an encoding
// format, scatters the signed immediate into its instruction bit positions
// (all non-immediate bits zero) and flags immediates that do not fit.
//
// Ports:
//   opcode_i    [6:0]  instruction opcode
//   funct3_i    [2:0]  funct3, distinguishes shift-immediates within OP_IMM
//   imm_i       [31:0] full signed immediate
//   fmt_o              encoding format (FMT_BAD for unknown opcodes)
//   imm_bits_o  [31:0] immediate bits already placed in the instruction word
//   range_err_o        immediate out of range or misaligned for the format
// ---------------------------------------------------------------------------
module rv_imm_pack
  import rv_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output fmt_e        fmt_o,
  output logic [31:0] imm_bits_o,
  output logic        range_err_o
);

  always_comb begin
    fmt_o       = FMT_BAD;
    imm_bits_o  = '0;
    range_err_o = 1'b0;
    unique case (opcode_i)
      OP_R: begin
        fmt_o = FMT_R;
      end
      OP_IMM: begin
        // slli/srli/srai carry a 5-bit shamt instead of a 12-bit immediate
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          fmt_o       = FMT_SHIFT;
          imm_bits_o  = {7'b0, imm_i[4:0], 20'b0};
          range_err_o = !in_range(imm_i, 0, 31);
        end else begin
          fmt_o       = FMT_I;
          imm_bits_o  = {imm_i[11:0], 20'b0};
          range_err_o = !in_range(imm_i, -2048, 2047);
        end
      end
      OP_LOAD, OP_JALR: begin
        fmt_o       = FMT_I;
        imm_bits_o  = {imm_i[11:0], 20'b0};
        range_err_o = !in_range(imm_i, -2048, 2047);
      end
      OP_STORE: begin
        fmt_o       = FMT_S;
        imm_bits_o  = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        range_err_o = !in_range(imm_i, -2048, 2047);
      end
      OP_BRANCH: begin
        // bit 0 is implied zero, so odd offsets are unencodable
        fmt_o       = FMT_B;
        imm_bits_o  = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        range_err_o = imm_i[0] || !in_range(imm_i, -4096, 4094);
      end
      OP_LUI, OP_AUIPC: begin
        fmt_o       = FMT_U;
        imm_bits_o  = {imm_i[31:12], 12'b0};
        range_err_o = (imm_i[11:0] != 12'b0);
      end
      OP_JAL: begin
        fmt_o       = FMT_J;
        imm_bits_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        range_err_o = imm_i[0] || !in_range(imm_i, -1048576, 1048574);
      end
      default: begin
        fmt_o = FMT_BAD;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I encoder: packs decoded fields plus a signed immediate into
// a 32-bit instruction word, substitutes a NOP on encoding errors and tags
// each word with a sequential byte address. One registered output stage with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   clear                sync: drop pending word, restart address and count
//   in_valid / in_ready  input handshake
//   opcode, funct3, funct7, rs1, rs2, rd, imm   decoded fields
//   out_valid / out_ready output handshake
//   out_instr            encoded word (NOP when out_err)
//   out_addr             byte address of out_instr
//   out_err              word was replaced by a NOP
//   word_count           saturating count of output handshakes
// ---------------------------------------------------------------------------
module instr_encoder
  import rv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       word_count
);

  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(4);

  fmt_e        fmt;
  logic [31:0] imm_bits;
  logic        range_err;

  logic [31:0]       instr_d;
  logic              err_d;

  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic              out_err_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [15:0]       word_count_q;

  logic accept;
  logic handshake;

  rv_imm_pack u_imm_pack (
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .imm_i       (imm),
    .fmt_o       (fmt),
    .imm_bits_o  (imm_bits),
    .range_err_o (range_err)
  );

  // The output register frees up when empty or draining this cycle; clear
  // blocks acceptance so nothing slips in across the restart.
  assign in_ready  = !clear && (!out_valid_q || out_out_ready_w());
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  function automatic logic out_out_ready_w();
    return out_ready;
  endfunction

  // Merge register/funct fields with the pre-placed immediate bits
  always_comb begin
    instr_d = NOP_INSTR;
    err_d   = 1'b0;
    unique case (fmt)
      FMT_R:     instr_d = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_SHIFT: instr_d = imm_bits | {funct7, 5'b0, rs1, funct3, rd, opcode};
      FMT_I:     instr_d = imm_bits | {12'b0, rs1, funct3, rd, opcode};
      FMT_S,
      FMT_B:     instr_d = imm_bits | {7'b0, rs2, rs1, funct3, 5'b0, opcode};
      FMT_U,
      FMT_J:     instr_d = imm_bits | {20'b0, rd, opcode};
      default:   instr_d = NOP_INSTR;
    endcase
    if (fmt == FMT_BAD || range_err) begin
      instr_d = NOP_INSTR;
      err_d   = 1'b1;
    end
  end

  // next_addr_q is the address the next loaded word will carry, so out_addr
  // only moves when a new word is actually presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_err_q    <= 1'b0;
      out_addr_q   <= BASE;
      next_addr_q  <= BASE;
      word_count_q <= '0;
    end else if (clear) begin
      out_valid_q  <= 1'b0;
      out_addr_q   <= BASE;
      next_addr_q  <= BASE;
      word_count_q <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_instr_q <= instr_d;
        out_err_q   <= err_d;
        out_addr_q  <= next_addr_q;
        next_addr_q <= next_addr_q + ADDR_INC;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
      if (handshake && word_count_q != 16'hFFFF) begin
        word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_err    = out_err_q;
  assign out_addr   = out_addr_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Directed vectors with hand-computed encodings. Stimulus pushes the expected
// word/address/error into a scoreboard queue at acceptance; an independent
// monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] word_count;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sbQ[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          popCount    = 0;
  logic [31:0] expAddr     = BASE;

  instr_encoder #(.BASE_ADDR(BASE), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .word_count (word_count)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Single comparison point; every check steps the shared counters
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one input word and wait (bounded) for acceptance; the expected
  // response is queued on the cycle the encoder takes it.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdv,
                               input logic [31:0] immv, input logic [31:0] expInstr,
                               input logic expErr);
    logic done;
    exp_t e;
    done     = 1'b0;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    rs1      = r1;
    rs2      = r2;
    rd       = rdv;
    imm      = immv;
    in_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = expInstr;
        e.addr  = expAddr;
        e.err   = expErr;
        sbQ.push_back(e);
        expAddr = expAddr + 32'd4;
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: in_ready never rose for %h", expInstr);
    end
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic drain();
    for (int t = 0; t < 64 && sbQ.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_queue_empty", 32'(sbQ.size()), 32'd0);
  endtask

  task automatic restartModel();
    sbQ.delete();
    expAddr  = BASE;
    popCount = 0;
  endtask

  // Monitor: compare every presented word at its handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_word: got %h @%h, required none", out_instr, out_addr);
      end else begin
        e = sbQ.pop_front();
        checkOutput("out_instr", out_instr, e.instr);
        checkOutput("out_addr", out_addr, e.addr);
        checkOutput("out_err", 32'(out_err), 32'(e.err));
        popCount++;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    funct3    = '0;
    funct7    = '0;
    rs1       = '0;
    rs2       = '0;
    rd        = '0;
    imm       = '0;

    #12;
    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_addr", out_addr, BASE);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] streaming encodings");
    applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5,        32'h0050_0093, 1'b0);
    applyStimulus(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd7, 32'd8,        32'h0020_A423, 1'b0);
    applyStimulus(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd9, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    applyStimulus(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    applyStimulus(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    applyStimulus(7'h13, 3'd5, 7'h20, 5'd3, 5'd0, 5'd3, 32'd4,        32'h4041_D193, 1'b0);
    applyStimulus(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0,        32'h0020_81B3, 1'b0);
    applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
    applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2047,     32'h7FF0_0013, 1'b0);

    $display("[TB] error substitution");
    applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd4096,     NOP, 1'b1);
    applyStimulus(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,        NOP, 1'b1);
    applyStimulus(7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0,        NOP, 1'b1);
    applyStimulus(7'h13, 3'd1, 7'h00, 5'd1, 5'd0, 5'd1, 32'd32,       NOP, 1'b1);
    applyStimulus(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5001, NOP, 1'b1);
    applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFF_F7FF, NOP, 1'b1);
    drain();
    checkOutput("word_count_stream", 32'(word_count), 32'(popCount));

    $display("[TB] backpressure");
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    restartModel();
    checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_word_count", 32'(word_count), 32'd0);
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0050_0093, 1'b0);
        applyStimulus(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8, 32'h0020_A423, 1'b0);
        applyStimulus(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0);
      end
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid && t < 20);
        checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
          if (c != 0) @(negedge clk);
          checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
          checkOutput("bp_hold_instr", out_instr, 32'h0050_0093);
          checkOutput("bp_hold_addr", out_addr, BASE);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("bp_word_count", 32'(word_count), 32'd3);

    $display("[TB] clear with pending word and input");
    out_ready = 1'b0;
    applyStimulus(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    opcode   = 7'h13;
    funct3   = 3'd0;
    rd       = 5'd2;
    imm      = 32'd1;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    checkOutput("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    restartModel();
    checkOutput("clr2_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr2_word_count", 32'(word_count), 32'd0);
    out_ready = 1'b1;
    applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0050_0093, 1'b0);
    drain();

    $display("[TB] async reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_out_instr", out_instr, 32'd0);
    checkOutput("arst_out_err", 32'(out_err), 32'd0);
    checkOutput("arst_out_addr", out_addr, BASE);
    checkOutput("arst_word_count", 32'(word_count), 32'd0);
    restartModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    applyStimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd4096,     NOP, 1'b1);
    drain();
    checkOutput("final_word_count", 32'(word_count), 32'(popCount));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
